load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data memory interface. Sits between the execute stage and data_memory, and drives Mem_Read, Mem_Write, Read_addr and Write_Data.
- Converts byte, halfword and word loads and stores (RV32I funct3) into word-only memory transactions:
  - Loads are aligned and then sign- or zero-extended.
  - Sub-word stores use read-modify-write.
  - Misaligned accesses are rejected.

Parameters:
- DATA_W, 32, data and address width.
- MEM_IDX_W, 30, width of the word index driven on Read_addr; upper Read_addr bits are driven 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  access request from the pipeline
- req_ready  out  1  unit can accept a request
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU for loads; 000 SB, 001 SH, 010 SW for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data, 0 for stores
- resp_err  out  1  misaligned access or illegal funct3
- Mem_Read  out  1  memory read strobe
- Mem_Write  out  1  memory write strobe, sampled by memory at posedge
- Read_addr  out  32  word index = {2'b00, req_addr[31:2]}
- Write_Data  out  32  full word to write
- Mem_data_in  in  32  memory read data; combinational from Read_addr, valid in the same cycle

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - req_ready=1; resp_valid, resp_err, Mem_Read, Mem_Write=0.
  - Read_addr, Write_Data, resp_rdata=0.
- FSM states: IDLE, RD, MERGE_WR, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, funct3, store, wdata, then:
  - error (misaligned or illegal funct3) -> RESP with err flag set;
  - load -> RD;
  - SW -> WR;
  - SB/SH -> RD with rmw flag set.
- Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal funct3 means 011/110/111, or a store with funct3 >=100.
- RD: Mem_Read=1, Read_addr driven. Capture Mem_data_in at the edge.
  - Load -> RESP.
  - rmw -> MERGE_WR.
- MERGE_WR: Mem_Write=1. Write_Data = captured word with the target byte (addr[1:0]) or halfword (addr[1]) replaced by wdata[7:0]/[15:0]; other bytes unchanged. Next state RESP.
- WR: Mem_Write=1, Write_Data=wdata. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_err per error flag; resp_rdata=extended load data (0 on store or error). Next state IDLE.
- No memory strobe is ever asserted for an errored request.
- Latency from accept edge to resp_valid:
  - LW/LB/LH/LBU/LHU: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Mem_Read and Mem_Write are never high in the same cycle.
- Request inputs are ignored when not in IDLE; there is no queueing.
- Extension: LB/LH replicate bit 7/15; LBU/LHU zero-fill.
- Reset mid-operation: strobes drop asynchronously. A partial RMW never writes, because the write occurs only in MERGE_WR.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after RESP.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs perf_loads, perf_stores, perf_errs.
  - Counters increment in RESP per completed access: loads and stores only when not errored; errs when errored.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding typedef lsu_state_t;
  - DATA_W default.
- Sub-module lsu_load_align: combinational byte/halfword select plus extension from (word, addr[1:0], funct3).

Test Plan:
- Word 4 = 0x80007F80:
  - LB 0x10 -> resp_rdata 0xFFFFFF80, 2 cycles;
  - LBU 0x11 -> 0x0000007F;
  - LH 0x12 -> 0xFFFF8000;
  - LHU 0x12 -> 0x00008000.
- Word 10 = 0x00000064, SB addr 0x29 wdata 0x123456AB -> one Mem_Read, then one Mem_Write with 0x0000AB64; resp at cycle 3; a subsequent LW 0x28 returns 0x0000AB64.
- SW 0x44 data 100 then LW 0x44 -> Write_Data=100 with Read_addr=17, then resp_rdata=100; no Mem_Read during the store.
- LW 0x42, SH 0x13, funct3=011 -> resp_err=1 after 1 cycle; Mem_Read and Mem_Write stay 0; resp_rdata=0.
- rst driven low during MERGE_WR of an SH -> Mem_Write falls without waiting for an edge; target word unchanged; req_ready=1 after release.
- LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned -> perf_loads=3, perf_stores=2, perf_errs=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding, default data width and request legality check.
package lsu_pkg;

  localparam int LSU_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE_WR,
    WR,
    RESP
  } lsu_state_t;

  // Illegal encodings plus misaligned halfword/word accesses.
  function automatic logic req_error(input logic store, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic illegal, misal;
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (store && f3[2]);
    misal   = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal || misal;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension; LW passes the word through.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_H:    data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_HU:   data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I byte/halfword/word accesses into word-only
// memory transactions. Sub-word stores are done as read-modify-write.
// Optional macro LSU_PERF_CNT_EN adds load/store/error completion counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W    = LSU_DATA_W,
  parameter int MEM_IDX_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [DATA_W-1:0] Read_addr,
  output logic [DATA_W-1:0] Write_Data,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_errs,
`endif
  input  logic [DATA_W-1:0] Mem_data_in
);

  lsu_state_t        state, nxt;
  logic [DATA_W-1:0] addr_q, wdata_q, word_q, merged, load_data, word_idx;
  logic [2:0]        f3_q;
  logic              store_q, err_q, rmw_q;

  assign word_idx = {{(DATA_W-MEM_IDX_W){1'b0}}, addr_q[MEM_IDX_W+1:2]};

  // State register; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Request latch on accept, memory word capture at the end of RD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      rmw_q   <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
      store_q <= req_store;
      err_q   <= req_error(req_store, req_funct3, req_addr[1:0]);
      rmw_q   <= req_store && (req_funct3 != F3_W);
    end else if (state == RD) begin
      word_q  <= Mem_data_in;
    end
  end

  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .word    (word_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (load_data)
  );

  // Splice store data into the captured word; untouched bytes keep old value.
  always_comb begin
    merged = word_q;
    if (f3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0]  = wdata_q[15:0];
    end
  end

  // Next state and Moore outputs; strobes exist only in RD/MERGE_WR/WR.
  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    Read_addr  = '0;
    Write_Data = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_error(req_store, req_funct3, req_addr[1:0])) nxt = RESP;
          else if (req_store && req_funct3 == F3_W)             nxt = WR;
          else                                                  nxt = RD;
        end
      end
      RD: begin
        Mem_Read  = 1'b1;
        Read_addr = word_idx;
        nxt       = rmw_q ? MERGE_WR : RESP;
      end
      MERGE_WR: begin
        Mem_Write  = 1'b1;
        Read_addr  = word_idx;
        Write_Data = merged;
        nxt        = RESP;
      end
      WR: begin
        Mem_Write  = 1'b1;
        Read_addr  = word_idx;
        Write_Data = wdata_q;
        nxt        = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (!store_q && !err_q) ? load_data : '0;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef LSU_PERF_CNT_EN
  // Completion counters, bumped once per RESP; free-running wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else if (state == RESP) begin
      if (err_q)        perf_errs   <= perf_errs + 32'd1;
      else if (store_q) perf_stores <= perf_stores + 32'd1;
      else              perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a combinational-read word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk, rst, req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata, Read_addr, Write_Data, Mem_data_in;
  logic        resp_valid, resp_err, Mem_Read, Mem_Write;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Read_addr(Read_addr), .Write_Data(Write_Data),
`ifdef LSU_PERF_CNT_EN
    .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs),
`endif
    .Mem_data_in(Mem_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory, with a preload port driven by the stimulus
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  assign Mem_data_in = mem[Read_addr[5:0]];
  always @(posedge clk) begin
    if (Mem_Write) mem[Read_addr[5:0]] <= Write_Data;
    if (pl_en)     mem[pl_idx] <= pl_data;
  end

  // strobe monitor
  int          n_rd = 0, n_wr = 0, n_both = 0;
  logic [31:0] last_wa = '0, last_wd = '0;
  always @(negedge clk) begin
    if (Mem_Read) n_rd++;
    if (Mem_Write) begin
      n_wr++;
      last_wa = Read_addr;
      last_wd = Write_Data;
    end
    if (Mem_Read && Mem_Write) n_both++;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0;
  int t_ld = 0, t_st = 0, t_er = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 6'(idx); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input int nrd, input int nwr);
    exp_t e;
    int l, rd0, wr0;
    @(negedge clk);
    chk("ready", 32'(req_ready), 1);
    chk("pulse", 32'(resp_valid), 0);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    e = '{rdata: er, err: ee, lat: lat, rd: nrd, wr: nwr};
    sb.push_back(e);
    rd0 = n_rd; wr0 = n_wr;
    @(posedge clk);
    #1 req_valid = 1'b0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!resp_valid && l < 10);
    e = sb.pop_front();
    if (!resp_valid) chk("timeout", 0, 1);
    else begin
      chk("lat", l, e.lat);
      chk("rdata", resp_rdata, e.rdata);
      chk("err", 32'(resp_err), 32'(e.err));
      chk("n_rd", n_rd - rd0, e.rd);
      chk("n_wr", n_wr - wr0, e.wr);
      if (ee)      t_er++;
      else if (st) t_st++;
      else         t_ld++;
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      F3_B:    return 32'($signed(sh[7:0]));
      F3_H:    return 32'($signed(sh[15:0]));
      F3_BU:   return {24'b0, sh[7:0]};
      F3_HU:   return {16'b0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3 == F3_B) ? (32'hFF << {a, 3'b000}) :
           (f3 == F3_H) ? (32'hFFFF << {a, 3'b000}) : 32'hFFFF_FFFF;
    return (w & ~mask) | ((wd << {a, 3'b000}) & mask);
  endfunction

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd, w;
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    #2;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_rvalid", 32'(resp_valid), 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_mrd", 32'(Mem_Read), 0);
    chk("rst_mwr", 32'(Mem_Write), 0);
    chk("rst_raddr", Read_addr, 0);
    chk("rst_wdata", Write_Data, 0);
    chk("rst_rdata", resp_rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // reset in the middle of an SH read-modify-write
    preload(5, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_H; req_addr = 32'h16; req_wdata = 32'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd", 32'(Mem_Read), 1);
    @(negedge clk);
    chk("rmw_wr", 32'(Mem_Write), 1);
    chk("rmw_data", Write_Data, 32'h1234_BEEF);
    #1 rst = 1'b0;
    #1;
    chk("arst_mwr", 32'(Mem_Write), 0);
    chk("arst_ready", 32'(req_ready), 1);
    chk("arst_raddr", Read_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    do_req(0, F3_W, 32'h14, 0, 32'hDEAD_BEEF, 0, 2, 1, 0);

    // load extension
    preload(4, 32'h8000_7F80);
    do_req(0, F3_B,  32'h10, 0, 32'hFFFF_FF80, 0, 2, 1, 0);
    do_req(0, F3_BU, 32'h11, 0, 32'h0000_007F, 0, 2, 1, 0);
    do_req(0, F3_H,  32'h12, 0, 32'hFFFF_8000, 0, 2, 1, 0);
    do_req(0, F3_HU, 32'h12, 0, 32'h0000_8000, 0, 2, 1, 0);
    do_req(0, F3_W,  32'h10, 0, 32'h8000_7F80, 0, 2, 1, 0);

    // SB read-modify-write
    preload(10, 32'h64);
    do_req(1, F3_B, 32'h29, 32'h1234_56AB, 0, 0, 3, 1, 1);
    chk("sb_wdata", last_wd, 32'h0000_AB64);
    chk("sb_waddr", last_wa, 10);
    do_req(0, F3_W, 32'h28, 0, 32'h0000_AB64, 0, 2, 1, 0);

    // SW then LW
    do_req(1, F3_W, 32'h44, 100, 0, 0, 2, 0, 1);
    chk("sw_wdata", last_wd, 100);
    chk("sw_waddr", last_wa, 17);
    do_req(0, F3_W, 32'h44, 0, 100, 0, 2, 1, 0);

    // errors: no strobes, 1-cycle latency, zero data
    do_req(0, F3_W,   32'h42, 0, 0, 1, 1, 0, 0);
    do_req(1, F3_H,   32'h13, 0, 0, 1, 1, 0, 0);
    do_req(0, 3'b011, 32'h10, 0, 0, 1, 1, 0, 0);
    do_req(1, F3_BU,  32'h10, 0, 0, 1, 1, 0, 0);
    do_req(0, F3_HU,  32'h11, 0, 0, 1, 1, 0, 0);

    // random aligned traffic against a reference memory
    for (int i = 20; i < 24; i++) preload(i, $urandom);
    for (int i = 0; i < 24; i++) begin
      st = 1'($urandom_range(0, 1));
      if (st) begin
        case ($urandom_range(0, 2))
          0:       f3 = F3_B;
          1:       f3 = F3_H;
          default: f3 = F3_W;
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0:       f3 = F3_B;
          1:       f3 = F3_H;
          2:       f3 = F3_W;
          3:       f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      a = 32'h50 + 32'($urandom_range(0, 15));
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      wd = $urandom;
      w = ref_mem[a[7:2]];
      if (st) begin
        if (f3 == F3_W) do_req(1, f3, a, wd, 0, 0, 2, 0, 1);
        else            do_req(1, f3, a, wd, 0, 0, 3, 1, 1);
        ref_mem[a[7:2]] = m_store(w, a[1:0], f3, wd);
      end else begin
        do_req(0, f3, a, 0, m_load(w, a[1:0], f3), 0, 2, 1, 0);
      end
    end

    @(negedge clk);
    chk("excl", n_both, 0);
`ifdef LSU_PERF_CNT_EN
    chk("perf_loads", perf_loads, t_ld);
    chk("perf_stores", perf_stores, t_st);
    chk("perf_errs", perf_errs, t_er);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
